// File: rtl/alu.sv
// Registered N-bit ALU: arithmetic, logic and shift operations with N/Z/C/V flags.
// The result and flags are computed combinationally and registered once per clock edge.
module alu #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         ci,
    input  logic [3:0]   selec_alu,
    output logic [N-1:0] result,
    output logic         flagN,
    output logic         flagZ,
    output logic         flagC,
    output logic         flagV
);

    localparam int unsigned WS = N + 1;
    localparam int unsigned WP = 2 * N;

    typedef enum logic [3:0] {
        OP_ADD = 4'b0000,
        OP_SUB = 4'b0001,
        OP_MUL = 4'b0010,
        OP_DIV = 4'b0011,
        OP_MOD = 4'b0100,
        OP_AND = 4'b0101,
        OP_OR  = 4'b0110,
        OP_XOR = 4'b0111,
        OP_SHL = 4'b1000,
        OP_SHR = 4'b1001
    } op_e;

    logic [WS-1:0] sum;
    logic [WS-1:0] dif;
    logic [WP-1:0] prod;
    logic [N-1:0]  nxt_result;
    logic          nxt_n;
    logic          nxt_z;
    logic          nxt_c;
    logic          nxt_v;

    // Next-state result and flags; the extra MSB of sum/dif carries the carry/borrow out.
    always_comb begin
        sum        = {1'b0, a} + {1'b0, b} + WS'(ci);
        dif        = {1'b0, a} - {1'b0, b} - WS'(ci);
        prod       = WP'(a) * WP'(b);
        nxt_result = '0;
        nxt_c      = 1'b0;
        nxt_v      = 1'b0;

        case (selec_alu)
            OP_ADD: begin
                nxt_result = sum[N-1:0];
                nxt_c      = sum[N];
                nxt_v      = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
            end
            OP_SUB: begin
                nxt_result = dif[N-1:0];
                nxt_c      = dif[N];
                nxt_v      = (a[N-1] != b[N-1]) && (dif[N-1] != a[N-1]);
            end
            OP_MUL: begin
                nxt_result = prod[N-1:0];
                nxt_v      = |prod[WP-1:N];
            end
            OP_DIV: begin
                nxt_result = (b == '0) ? '1 : a / b;
                nxt_v      = (b == '0);
            end
            OP_MOD: begin
                nxt_result = (b == '0) ? a : a % b;
                nxt_v      = (b == '0);
            end
            OP_AND: nxt_result = a & b;
            OP_OR:  nxt_result = a | b;
            OP_XOR: nxt_result = a ^ b;
            OP_SHL: begin
                nxt_result = {a[N-2:0], 1'b0};
                nxt_c      = a[N-1];
            end
            OP_SHR: begin
                nxt_result = {1'b0, a[N-1:1]};
                nxt_c      = a[0];
            end
            default: begin
                nxt_result = '0;
            end
        endcase

        nxt_n = nxt_result[N-1];
        nxt_z = (nxt_result == '0);
    end

    // Output registers with synchronous active-low reset taking priority.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result <= '0;
            flagN  <= 1'b0;
            flagZ  <= 1'b0;
            flagC  <= 1'b0;
            flagV  <= 1'b0;
        end else begin
            result <= nxt_result;
            flagN  <= nxt_n;
            flagZ  <= nxt_z;
            flagC  <= nxt_c;
            flagV  <= nxt_v;
        end
    end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu (N=4): expected {result,N,Z,C,V} words are queued when
// stimulus is applied and popped when the registered outputs are sampled.
module tb_alu;

    localparam int unsigned N = 4;
    localparam int          M = 1 << N;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         ci;
    logic [3:0]   selec_alu;
    logic [N-1:0] result;
    logic         flagN;
    logic         flagZ;
    logic         flagC;
    logic         flagV;

    typedef logic [N+3:0] obs_t;

    typedef struct {
        logic [3:0]   op;
        logic [N-1:0] va;
        logic [N-1:0] vb;
        logic         vci;
        logic [N-1:0] res;
        logic         c;
        logic         v;
    } vec_t;

    obs_t sb[$];
    int   checks = 0;
    int   errors = 0;
    obs_t exp_w;
    obs_t held;

    always #5 clk = ~clk;

    alu #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .ci        (ci),
        .selec_alu (selec_alu),
        .result    (result),
        .flagN     (flagN),
        .flagZ     (flagZ),
        .flagC     (flagC),
        .flagV     (flagV)
    );

    function automatic obs_t pack_exp(int r, bit c, bit v);
        logic [N-1:0] rr;
        rr = N'(r);
        return {rr, rr[N-1], (rr == '0), c, v};
    endfunction

    function automatic int sgn(logic [N-1:0] x);
        int ix;
        ix = int'(x);
        return (ix >= M / 2) ? ix - M : ix;
    endfunction

    // Reference model written with integer arithmetic.
    function automatic obs_t model(logic [3:0] op, logic [N-1:0] xa, logic [N-1:0] xb, logic xc);
        int  ia, ib, s, r;
        bit  c, v;
        ia = int'(xa);
        ib = int'(xb);
        r  = 0;
        c  = 0;
        v  = 0;
        case (op)
            4'd0: begin
                s = ia + ib + int'(xc);
                r = s % M;
                c = (s >= M);
                s = sgn(xa) + sgn(xb) + int'(xc);
                v = (s > M / 2 - 1) || (s < -(M / 2));
            end
            4'd1: begin
                s = ia - ib - int'(xc);
                r = (s + 2 * M) % M;
                c = (s < 0);
                s = sgn(xa) - sgn(xb) - int'(xc);
                v = (s > M / 2 - 1) || (s < -(M / 2));
            end
            4'd2: begin
                s = ia * ib;
                r = s % M;
                v = (s >= M);
            end
            4'd3: begin
                if (ib == 0) begin r = M - 1; v = 1; end
                else r = ia / ib;
            end
            4'd4: begin
                if (ib == 0) begin r = ia; v = 1; end
                else r = ia % ib;
            end
            4'd5: r = int'(xa & xb);
            4'd6: r = int'(xa | xb);
            4'd7: r = int'(xa ^ xb);
            4'd8: begin
                r = (ia * 2) % M;
                c = (ia >= M / 2);
            end
            4'd9: begin
                r = ia / 2;
                c = (ia % 2) == 1;
            end
            default: r = 0;
        endcase
        return pack_exp(r, c, v);
    endfunction

    function automatic obs_t observed();
        return {result, flagN, flagZ, flagC, flagV};
    endfunction

    task automatic drive(logic [3:0] op, logic [N-1:0] xa, logic [N-1:0] xb, logic xc);
        @(negedge clk);
        selec_alu = op;
        a         = xa;
        b         = xb;
        ci        = xc;
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rst_n     = 1'b0;
            selec_alu = 4'($urandom_range(0, 9));
            a         = N'($urandom_range(1, M - 1));
            b         = N'($urandom_range(1, M - 1));
            ci        = 1'($urandom_range(0, 1));
            sb.push_back('0);
            settle();
            exp_w = sb.pop_front();
            checks++;
            if (observed() !== exp_w) begin
                errors++;
                $display("FAIL reset[%0d] got %b want %b", i, observed(), exp_w);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_vectors();
        vec_t tbl[$];
        tbl = '{
            '{4'd0, 4'b0111, 4'b0110, 1'b1, 4'b1110, 1'b0, 1'b1},
            '{4'd0, 4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0},
            '{4'd0, 4'b1010, 4'b1001, 1'b1, 4'b0100, 1'b1, 1'b1},
            '{4'd1, 4'b1000, 4'b0110, 1'b1, 4'b0001, 1'b0, 1'b1},
            '{4'd1, 4'b1110, 4'b1110, 1'b0, 4'b0000, 1'b0, 1'b0},
            '{4'd1, 4'b1000, 4'b1110, 1'b1, 4'b1001, 1'b1, 1'b0},
            '{4'd1, 4'b0001, 4'b1000, 1'b0, 4'b1001, 1'b1, 1'b1},
            '{4'd2, 4'b1010, 4'b0110, 1'b1, 4'b1100, 1'b0, 1'b1},
            '{4'd2, 4'b0010, 4'b0110, 1'b0, 4'b1100, 1'b0, 1'b0},
            '{4'd2, 4'b0001, 4'b0111, 1'b1, 4'b0111, 1'b0, 1'b0},
            '{4'd2, 4'b0000, 4'b0011, 1'b0, 4'b0000, 1'b0, 1'b0},
            '{4'd3, 4'b1110, 4'b0011, 1'b1, 4'b0100, 1'b0, 1'b0},
            '{4'd3, 4'b0111, 4'b0010, 1'b0, 4'b0011, 1'b0, 1'b0},
            '{4'd4, 4'b1010, 4'b0110, 1'b1, 4'b0100, 1'b0, 1'b0},
            '{4'd4, 4'b1000, 4'b0101, 1'b0, 4'b0011, 1'b0, 1'b0},
            '{4'd3, 4'b0101, 4'b0000, 1'b1, 4'b1111, 1'b0, 1'b1},
            '{4'd4, 4'b0101, 4'b0000, 1'b0, 4'b0101, 1'b0, 1'b1},
            '{4'd5, 4'b1001, 4'b1110, 1'b1, 4'b1000, 1'b0, 1'b0},
            '{4'd6, 4'b0010, 4'b1000, 1'b1, 4'b1010, 1'b0, 1'b0},
            '{4'd7, 4'b1010, 4'b1100, 1'b0, 4'b0110, 1'b0, 1'b0},
            '{4'd8, 4'b1010, 4'b1111, 1'b1, 4'b0100, 1'b1, 1'b0},
            '{4'd9, 4'b0011, 4'b1111, 1'b1, 4'b0001, 1'b1, 1'b0},
            '{4'd9, 4'b0001, 4'b0101, 1'b0, 4'b0000, 1'b1, 1'b0},
            '{4'd10, 4'b1111, 4'b1111, 1'b1, 4'b0000, 1'b0, 1'b0},
            '{4'd15, 4'b0111, 4'b0001, 1'b1, 4'b0000, 1'b0, 1'b0}
        };
        foreach (tbl[i]) begin
            drive(tbl[i].op, tbl[i].va, tbl[i].vb, tbl[i].vci);
            sb.push_back(pack_exp(int'(tbl[i].res), tbl[i].c, tbl[i].v));
            settle();
            exp_w = sb.pop_front();
            checks++;
            if (observed() !== exp_w) begin
                errors++;
                $display("FAIL vector[%0d] op=%0d a=%b b=%b ci=%b got %b want %b",
                         i, tbl[i].op, tbl[i].va, tbl[i].vb, tbl[i].vci, observed(), exp_w);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]   op;
        logic [N-1:0] xa, xb;
        logic         xc;
        for (int i = 0; i < 300; i++) begin
            op = 4'($urandom_range(0, 15));
            xa = N'($urandom_range(0, M - 1));
            xb = N'($urandom_range(0, M - 1));
            xc = 1'($urandom_range(0, 1));
            drive(op, xa, xb, xc);
            sb.push_back(model(op, xa, xb, xc));
            settle();
            exp_w = sb.pop_front();
            checks++;
            if (observed() !== exp_w) begin
                errors++;
                $display("FAIL random[%0d] op=%0d a=%b b=%b ci=%b got %b want %b",
                         i, op, xa, xb, xc, observed(), exp_w);
            end
        end
    endtask

    task automatic test_reset_sequence();
        drive(4'd0, 4'b1111, 4'b0001, 1'b0);
        sb.push_back(pack_exp(0, 1'b1, 1'b0));
        settle();
        exp_w = sb.pop_front();
        checks++;
        if (observed() !== exp_w) begin
            errors++;
            $display("FAIL rstseq_add got %b want %b", observed(), exp_w);
        end

        drive(4'd0, 4'b0111, 4'b0110, 1'b1);
        rst_n = 1'b0;
        sb.push_back('0);
        settle();
        exp_w = sb.pop_front();
        checks++;
        if (observed() !== exp_w) begin
            errors++;
            $display("FAIL rstseq_clear got %b want %b", observed(), exp_w);
        end

        drive(4'd8, 4'b0011, 4'b0000, 1'b0);
        rst_n = 1'b1;
        sb.push_back(pack_exp(6, 1'b0, 1'b0));
        settle();
        exp_w = sb.pop_front();
        held  = exp_w;
        checks++;
        if (observed() !== exp_w) begin
            errors++;
            $display("FAIL rstseq_release got %b want %b", observed(), exp_w);
        end

        // Reset pulse and input churn between edges must leave the outputs untouched.
        #1;
        rst_n     = 1'b0;
        a         = 4'b1001;
        selec_alu = 4'd2;
        #2;
        rst_n = 1'b1;
        checks++;
        if (observed() !== held) begin
            errors++;
            $display("FAIL rstseq_hold got %b want %b", observed(), held);
        end

        sb.push_back(model(4'd2, 4'b1001, b, ci));
        settle();
        exp_w = sb.pop_front();
        checks++;
        if (observed() !== exp_w) begin
            errors++;
            $display("FAIL rstseq_after_pulse got %b want %b", observed(), exp_w);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n     = 1'b0;
        a         = '0;
        b         = '0;
        ci        = 1'b0;
        selec_alu = 4'd0;
        test_reset();
        test_vectors();
        test_reset_sequence();
        test_back_to_back();
        test_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
